// File: rtl/fft_serializer_pkg.sv
// Shared types and defaults for the FFT output serializer.
// Legacy frame timing defaults and the channel-index width helper live here.
package fft_serializer_pkg;

   typedef enum logic {
      SER_IDLE   = 1'b0,
      SER_STREAM = 1'b1
   } ser_state_t;

   localparam int unsigned SER_DEF_FRAME_LEN = 42;
   localparam int unsigned SER_DEF_CAP_SLOT  = 24;

   // Width of the channel index bus (SerChIdxBus); never narrower than one bit.
   function automatic int unsigned ser_ch_idx_w(input int unsigned num_ch);
      return (num_ch < 2) ? 1 : $clog2(num_ch);
   endfunction

endpackage

// File: rtl/ser_frame_counter.sv
// Free-running modulo-FRAME_LEN frame counter with a strobe on the capture slot.
// Never stalls; only reset returns it to zero.
module ser_frame_counter
   import fft_serializer_pkg::*;
#(
   parameter int unsigned FRAME_LEN = SER_DEF_FRAME_LEN,
   parameter int unsigned CAP_SLOT  = SER_DEF_CAP_SLOT
)(
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_slot_hit
);

   localparam int unsigned CNT_W = $clog2(FRAME_LEN);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_W'(FRAME_LEN - 1)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_slot_hit = (r_cnt == CNT_W'(CAP_SLOT));

endmodule

// File: rtl/fft_serializer.sv
// Parallel-to-serial output stage: captures NUM_CH samples into a shadow register
// and streams them channel 0..NUM_CH-1 with valid/ready flow control.
module fft_serializer
   import fft_serializer_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned NUM_CH    = 16,
   parameter int unsigned FREE_RUN  = 0,
   parameter int unsigned FRAME_LEN = SER_DEF_FRAME_LEN,
   parameter int unsigned CAP_SLOT  = SER_DEF_CAP_SLOT
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH*DATA_W-1:0] din,
   input  logic                     din_valid,
   output logic                     din_ready,
   output logic [DATA_W-1:0]        dout,
   output logic                     dout_valid,
   input  logic                     dout_ready,
   output logic                     dout_first,
   output logic                     dout_last,
   output logic                     overrun
);

   localparam int unsigned     CH_W     = ser_ch_idx_w(NUM_CH);
   localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_CH - 1);

   ser_state_t        r_state;
   logic [CH_W-1:0]   r_ch_idx;
   logic [DATA_W-1:0] r_shadow [NUM_CH];
   logic [DATA_W-1:0] r_dout;
   logic              r_valid;
   logic              r_overrun;
   logic              r_rdy_en;

   logic              w_cap_req;
   logic              w_beat;
   logic              w_last;
   logic              w_din_ready;
   logic              w_capture;
   logic [CH_W-1:0]   w_ch_nxt;

   generate
      if (FREE_RUN != 0) begin : g_free_run
         logic w_slot_hit;
         ser_frame_counter #(
            .FRAME_LEN (FRAME_LEN),
            .CAP_SLOT  (CAP_SLOT)
         ) u_frame_counter (
            .i_clk      (clk),
            .i_rst_n    (rst_n),
            .o_slot_hit (w_slot_hit)
         );
         assign w_cap_req = w_slot_hit;
      end else begin : g_triggered
         assign w_cap_req = din_valid;
      end
   endgenerate

   assign w_beat   = r_valid && dout_ready;
   assign w_last   = (r_ch_idx == LAST_IDX);
   assign w_ch_nxt = r_ch_idx + 1'b1;
   // r_rdy_en keeps din_ready low until the first clock after reset release.
   assign w_din_ready = r_rdy_en && ((r_state == SER_IDLE) || (w_beat && w_last));
   assign w_capture   = w_cap_req && w_din_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= SER_IDLE;
         r_ch_idx  <= '0;
         r_dout    <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
         r_rdy_en  <= 1'b0;
         for (int unsigned k = 0; k < NUM_CH; k++) begin
            r_shadow[k] <= '0;
         end
      end else begin
         r_rdy_en <= 1'b1;
         if (w_cap_req && !w_din_ready) begin
            r_overrun <= 1'b1;
         end
         if (w_capture) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
               r_shadow[k] <= din[k*DATA_W +: DATA_W];
            end
            r_dout   <= din[DATA_W-1:0];
            r_ch_idx <= '0;
            r_valid  <= 1'b1;
            r_state  <= SER_STREAM;
         end else if ((r_state == SER_STREAM) && w_beat) begin
            if (w_last) begin
               r_state  <= SER_IDLE;
               r_valid  <= 1'b0;
               r_ch_idx <= '0;
               r_dout   <= '0;
            end else begin
               r_ch_idx <= w_ch_nxt;
               r_dout   <= r_shadow[w_ch_nxt];
            end
         end
      end
   end

   assign din_ready  = w_din_ready;
   assign dout       = r_dout;
   assign dout_valid = r_valid;
   assign dout_first = r_valid && (r_ch_idx == '0);
   assign dout_last  = r_valid && w_last;
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_fft_serializer.sv
// Self-checking bench for fft_serializer: queue-based beat model for the
// triggered instance and a slot-timing model for the free-running instance.
module tb_fft_serializer;

   localparam int unsigned DW = 32;
   localparam int unsigned NC = 16;
   localparam int unsigned FL = 42;
   localparam int unsigned CS = 24;

   typedef struct {
      logic [DW-1:0] data;
      logic          first;
      logic          last;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NC*DW-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic [DW-1:0]    dout;
   logic             dout_valid;
   logic             dout_ready;
   logic             dout_first;
   logic             dout_last;
   logic             overrun;

   logic             rst_fr_n;
   logic [NC*DW-1:0] din_fr;
   logic             din_fr_valid;
   logic             din_fr_ready;
   logic [DW-1:0]    dout_fr;
   logic             dout_fr_valid;
   logic             dout_fr_ready;
   logic             dout_fr_first;
   logic             dout_fr_last;
   logic             overrun_fr;

   int unsigned total = 0;
   int unsigned bad   = 0;

   beat_t q[$];
   bit    m_en;
   bit    m_ovr;

   always #5 clk = ~clk;

   fft_serializer #(
      .DATA_W   (DW),
      .NUM_CH   (NC),
      .FREE_RUN (0)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_first (dout_first),
      .dout_last  (dout_last),
      .overrun    (overrun)
   );

   fft_serializer #(
      .DATA_W    (DW),
      .NUM_CH    (NC),
      .FREE_RUN  (1),
      .FRAME_LEN (FL),
      .CAP_SLOT  (CS)
   ) dut_fr (
      .clk        (clk),
      .rst_n      (rst_fr_n),
      .din        (din_fr),
      .din_valid  (din_fr_valid),
      .din_ready  (din_fr_ready),
      .dout       (dout_fr),
      .dout_valid (dout_fr_valid),
      .dout_ready (dout_fr_ready),
      .dout_first (dout_fr_first),
      .dout_last  (dout_fr_last),
      .overrun    (overrun_fr)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [NC*DW-1:0] ramp(input int unsigned base);
      logic [NC*DW-1:0] r;
      for (int unsigned k = 0; k < NC; k++) r[k*DW +: DW] = DW'(base + k);
      return r;
   endfunction

   function automatic logic [NC*DW-1:0] rnd_frame();
      logic [NC*DW-1:0] r;
      for (int unsigned k = 0; k < NC; k++) r[k*DW +: DW] = $urandom;
      return r;
   endfunction

   task automatic push_frame(input logic [NC*DW-1:0] d);
      beat_t b;
      for (int unsigned k = 0; k < NC; k++) begin
         b.data  = d[k*DW +: DW];
         b.first = (k == 0);
         b.last  = (k == NC - 1);
         q.push_back(b);
      end
   endtask

   task automatic check_outputs();
      bit v;
      v = (q.size() != 0);
      chk("dout_valid", dout_valid, v);
      if (v) begin
         chk("dout", dout, q[0].data);
         chk("dout_first", dout_first, q[0].first);
         chk("dout_last", dout_last, q[0].last);
      end else begin
         chk("dout_first_idle", dout_first, 1'b0);
         chk("dout_last_idle", dout_last, 1'b0);
      end
      chk("overrun", overrun, m_ovr);
   endtask

   // One clock of stimulus: drive inputs, check din_ready, advance the model,
   // then check outputs after the edge.
   task automatic cycle(input logic v, input logic [NC*DW-1:0] d, input logic rdy);
      bit acc;
      din_valid  = v;
      din        = d;
      dout_ready = rdy;
      #1;
      acc = m_en && ((q.size() == 0) || (rdy && q.size() == 1));
      chk("din_ready", din_ready, acc);
      if (rdy && q.size() != 0) void'(q.pop_front());
      if (v && acc) push_frame(d);
      else if (v) m_ovr = 1'b1;
      m_en = 1'b1;
      @(negedge clk);
      check_outputs();
   endtask

   task automatic do_reset();
      din        = rnd_frame();
      din_valid  = 1'($urandom_range(0, 1));
      dout_ready = 1'($urandom_range(0, 1));
      rst_n      = 1'b0;
      #1;
      chk("rst_dout", dout, '0);
      chk("rst_valid", dout_valid, 1'b0);
      chk("rst_first", dout_first, 1'b0);
      chk("rst_last", dout_last, 1'b0);
      chk("rst_overrun", overrun, 1'b0);
      chk("rst_din_ready", din_ready, 1'b0);
      q.delete();
      m_ovr = 1'b0;
      m_en  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_hold_valid", dout_valid, 1'b0);
      chk("rst_hold_din_ready", din_ready, 1'b0);
      din_valid = 1'b0;
      rst_n     = 1'b1;
   endtask

   initial begin
      logic [DW-1:0] lat [NC];
      int unsigned   s;
      bit            ev;

      rst_fr_n      = 1'b0;
      din_fr        = '0;
      din_fr_valid  = 1'b0;
      dout_fr_ready = 1'b1;
      rst_n         = 1'b0;
      for (int unsigned k = 0; k < NC; k++) lat[k] = '0;

      // Reset with random inputs, then one idle cycle to open din_ready.
      do_reset();
      cycle(1'b0, rnd_frame(), 1'b1);

      // Single frame, sink always ready.
      cycle(1'b1, ramp(1), 1'b1);
      repeat (17) cycle(1'b0, rnd_frame(), 1'b1);

      // Backpressure for three cycles while ch 5 is presented.
      cycle(1'b1, ramp(1), 1'b1);
      repeat (5) cycle(1'b0, rnd_frame(), 1'b1);
      repeat (3) cycle(1'b0, rnd_frame(), 1'b0);
      repeat (12) cycle(1'b0, rnd_frame(), 1'b1);

      // Back-to-back frames, second request on the first frame's last beat.
      cycle(1'b1, ramp(100), 1'b1);
      repeat (15) cycle(1'b0, rnd_frame(), 1'b1);
      cycle(1'b1, ramp(200), 1'b1);
      repeat (17) cycle(1'b0, rnd_frame(), 1'b1);

      // Capture request mid-stream is dropped and flags overrun.
      cycle(1'b1, ramp(1), 1'b1);
      repeat (3) cycle(1'b0, rnd_frame(), 1'b1);
      cycle(1'b1, ramp(500), 1'b1);
      repeat (14) cycle(1'b0, rnd_frame(), 1'b1);
      chk("overrun_sticky", overrun, 1'b1);

      do_reset();
      cycle(1'b0, rnd_frame(), 1'b1);

      // Randomized traffic with occasional mid-frame reset.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 149) == 0) begin
            do_reset();
         end
         cycle(1'($urandom_range(0, 3) == 0), rnd_frame(), 1'($urandom_range(0, 3) != 0));
      end

      // Free-running instance: capture at slot CS, ch k at slot CS+1+k.
      @(negedge clk);
      #1;
      chk("fr_rst_valid", dout_fr_valid, 1'b0);
      chk("fr_rst_din_ready", din_fr_ready, 1'b0);
      rst_fr_n = 1'b1;
      for (int unsigned k = 0; k < FL * 3 + 5; k++) begin
         s  = k % FL;
         ev = (k > CS) && (s > CS) && (s <= CS + NC);
         chk("fr_valid", dout_fr_valid, ev);
         chk("fr_first", dout_fr_first, ev && (s == CS + 1));
         chk("fr_last", dout_fr_last, ev && (s == CS + NC));
         if (ev) chk("fr_dout", dout_fr, lat[s-CS-1]);
         chk("fr_din_ready", din_fr_ready, (k != 0) && !(ev && s < CS + NC));
         chk("fr_overrun", overrun_fr, 1'b0);
         din_fr = rnd_frame();
         if (s == CS) begin
            for (int unsigned c = 0; c < NC; c++) lat[c] = din_fr[c*DW +: DW];
         end
         @(negedge clk);
         #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
